// File: rtl/rv32i_types.sv
`default_nettype none
// ============================================================================
// Package  : rv32i_types
// Brief    : Shared RV32I word type, fetch queue entry and NOP encoding.
// Revision : 1.0 - initial release
// ============================================================================
package rv32i_types;

  typedef logic [31:0] rv32i_word;

  // One fetched instruction as seen by decode.
  typedef struct packed {
    rv32i_word pc;
    rv32i_word instr;
    logic      br_pred;
  } fetch_entry_t;

  // addi x0, x0, 0
  localparam rv32i_word NOP_INSTR = 32'h00000013;

endpackage
`default_nettype wire

// File: rtl/fetch_queue_ptr.sv
`default_nettype none
// ============================================================================
// Module   : fq_ptr
// Brief    : Wrapping PTR_W-bit pointer with increment and synchronous clear.
// Revision : 1.0 - initial release
// ============================================================================
module fq_ptr #(
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [PTR_W-1:0] o_ptr
);

  logic [PTR_W-1:0] r_ptr;

  // Clear has priority over increment; wrap comes from natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_clr) begin
      r_ptr <= '0;
    end else if (i_inc) begin
      r_ptr <= r_ptr + PTR_W'(1);
    end
  end

  assign o_ptr = r_ptr;

endmodule
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Brief    : Fetch-to-decode decoupling FIFO with single-cycle flush.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue
  import rv32i_types::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enq_valid_i,
  input  logic [31:0]      enq_pc_i,
  input  logic [31:0]      enq_instr_i,
  input  logic             enq_br_pred_i,
  output logic             enq_ready_o,
  input  logic             deq_ready_i,
  output logic             deq_valid_o,
  output logic [31:0]      deq_pc_o,
  output logic [31:0]      deq_instr_o,
  output logic             deq_br_pred_o,
  input  logic             flush_i,
  output logic [PTR_W:0]   count_o
);

  localparam logic [PTR_W:0] c_FULL = (PTR_W+1)'(DEPTH);

  // Reject depths the pointer arithmetic cannot wrap correctly.
  generate
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("fetch_queue: DEPTH must be a power of two and at least 2");
    end
  endgenerate

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W:0]   r_count;
  logic [PTR_W-1:0] w_rd_ptr;
  logic [PTR_W-1:0] w_wr_ptr;
  logic             w_enq;
  logic             w_deq;
  fetch_entry_t     w_head;

  assign enq_ready_o = (r_count != c_FULL);
  assign deq_valid_o = (r_count != '0);
  assign w_enq       = enq_valid_i & enq_ready_o;
  assign w_deq       = deq_valid_o & deq_ready_i;
  assign count_o     = r_count;

  fq_ptr #(.PTR_W(PTR_W)) u_rd_ptr (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_deq),
    .i_clr (flush_i),
    .o_ptr (w_rd_ptr)
  );

  fq_ptr #(.PTR_W(PTR_W)) u_wr_ptr (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_enq),
    .i_clr (flush_i),
    .o_ptr (w_wr_ptr)
  );

  // Storage is not reset; an entry dropped by a flush is never written.
  always_ff @(posedge clk) begin
    if (w_enq && !flush_i) begin
      r_mem[w_wr_ptr] <= {enq_pc_i, enq_instr_i, enq_br_pred_i};
    end
  end

  // Occupancy tracks enqueue/dequeue; flush empties the queue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (flush_i) begin
      r_count <= '0;
    end else begin
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Head is a direct array read, replaced by a NOP bubble when empty.
  always_comb begin
    w_head        = r_mem[w_rd_ptr];
    deq_pc_o      = 32'h0;
    deq_instr_o   = NOP_INSTR;
    deq_br_pred_o = 1'b0;
    if (deq_valid_o) begin
      deq_pc_o      = w_head.pc;
      deq_instr_o   = w_head.instr;
      deq_br_pred_o = w_head.br_pred;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_queue
// Brief    : Self-checking bench for fetch_queue (vectors, corners, random).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enq_valid_i = 1'b0;
  logic [31:0] enq_pc_i = '0;
  logic [31:0] enq_instr_i = '0;
  logic        enq_br_pred_i = 1'b0;
  logic        enq_ready_o;
  logic        deq_ready_i = 1'b0;
  logic        deq_valid_o;
  logic [31:0] deq_pc_o;
  logic [31:0] deq_instr_o;
  logic        deq_br_pred_o;
  logic        flush_i = 1'b0;
  logic [2:0]  count_o;

  int total = 0;
  int bad   = 0;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .enq_valid_i   (enq_valid_i),
    .enq_pc_i      (enq_pc_i),
    .enq_instr_i   (enq_instr_i),
    .enq_br_pred_i (enq_br_pred_i),
    .enq_ready_o   (enq_ready_o),
    .deq_ready_i   (deq_ready_i),
    .deq_valid_o   (deq_valid_o),
    .deq_pc_o      (deq_pc_o),
    .deq_instr_o   (deq_instr_o),
    .deq_br_pred_o (deq_br_pred_o),
    .flush_i       (flush_i),
    .count_o       (count_o)
  );

  always #5 clk = ~clk;

  // Reference model: an ordered list of queued entries.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        bp;
  } ent_t;
  ent_t mq[$];

  // Occupancy must stay within 0..DEPTH.
  always @(negedge clk) begin
    if (!rst) begin
      total++;
      assert (count_o <= 3'(DEPTH))
      else begin
        bad++;
        $display("FAIL count_bound: got %0d want <= %0d", count_o, DEPTH);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    int n = mq.size();
    chk({tag, ".count"}, 32'(count_o), 32'(n));
    chk({tag, ".valid"}, 32'(deq_valid_o), 32'(n != 0));
    chk({tag, ".ready"}, 32'(enq_ready_o), 32'(n != DEPTH));
    chk({tag, ".pc"},    deq_pc_o,    (n != 0) ? mq[0].pc    : 32'h0);
    chk({tag, ".instr"}, deq_instr_o, (n != 0) ? mq[0].instr : NOP);
    chk({tag, ".bp"},    32'(deq_br_pred_o), (n != 0) ? 32'(mq[0].bp) : 32'h0);
  endtask

  task automatic model_step();
    bit e = enq_valid_i && (mq.size() < DEPTH);
    bit d = deq_ready_i && (mq.size() > 0);
    ent_t x;
    if (flush_i) begin
      mq.delete();
    end else begin
      if (d) x = mq.pop_front();
      if (e) begin
        x.pc = enq_pc_i; x.instr = enq_instr_i; x.bp = enq_br_pred_i;
        mq.push_back(x);
      end
    end
  endtask

  task automatic drive(input logic ev, input logic [31:0] pc, input logic bp,
                       input logic dr, input logic fl);
    enq_valid_i   = ev;
    enq_pc_i      = pc;
    enq_instr_i   = ~pc;
    enq_br_pred_i = bp;
    deq_ready_i   = dr;
    flush_i       = fl;
  endtask

  // One clock: drive, compare against model mid-cycle, clock the model.
  task automatic cyc(input string tag, input logic ev, input logic [31:0] pc,
                     input logic bp, input logic dr, input logic fl);
    drive(ev, pc, bp, dr, fl);
    @(negedge clk);
    check_model(tag);
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Asynchronous reset pulse asserted and released between edges.
  task automatic async_reset(input string tag);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    #1 rst = 1'b1;
    #1;
    chk({tag, ".count"}, 32'(count_o), 32'h0);
    chk({tag, ".valid"}, 32'(deq_valid_o), 32'h0);
    chk({tag, ".ready"}, 32'(enq_ready_o), 32'h1);
    chk({tag, ".instr"}, deq_instr_o, NOP);
    mq.delete();
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  typedef struct {
    logic        ev;
    logic [31:0] pc;
    logic        bp;
    logic        dr;
    logic [2:0]  e_cnt;
    logic        e_val;
    logic        e_rdy;
    logic [31:0] e_pc;
    logic        e_bp;
  } vec_t;
  vec_t vt[10];

  initial begin
    // Fill to full (fifth enqueue blocked), then drain in order.
    vt[0] = '{1'b1, 32'h60, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 32'h00, 1'b0};
    vt[1] = '{1'b1, 32'h64, 1'b1, 1'b0, 3'd1, 1'b1, 1'b1, 32'h60, 1'b0};
    vt[2] = '{1'b1, 32'h68, 1'b0, 1'b0, 3'd2, 1'b1, 1'b1, 32'h60, 1'b0};
    vt[3] = '{1'b1, 32'h6C, 1'b1, 1'b0, 3'd3, 1'b1, 1'b1, 32'h60, 1'b0};
    vt[4] = '{1'b1, 32'h70, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0, 32'h60, 1'b0};
    vt[5] = '{1'b0, 32'h00, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0, 32'h60, 1'b0};
    vt[6] = '{1'b0, 32'h00, 1'b0, 1'b1, 3'd3, 1'b1, 1'b1, 32'h64, 1'b1};
    vt[7] = '{1'b0, 32'h00, 1'b0, 1'b1, 3'd2, 1'b1, 1'b1, 32'h68, 1'b0};
    vt[8] = '{1'b0, 32'h00, 1'b0, 1'b1, 3'd1, 1'b1, 1'b1, 32'h6C, 1'b1};
    vt[9] = '{1'b0, 32'h00, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 32'h00, 1'b0};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // 1. reset mid-cycle then idle
    async_reset("t1_reset");
    @(posedge clk);
    #1;
    cyc("t1_idle", 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

    // 2. table-driven fill/drain
    for (int i = 0; i < 10; i++) begin
      drive(vt[i].ev, vt[i].pc, vt[i].bp, vt[i].dr, 1'b0);
      @(negedge clk);
      chk($sformatf("t2[%0d].count", i), 32'(count_o), 32'(vt[i].e_cnt));
      chk($sformatf("t2[%0d].valid", i), 32'(deq_valid_o), 32'(vt[i].e_val));
      chk($sformatf("t2[%0d].ready", i), 32'(enq_ready_o), 32'(vt[i].e_rdy));
      chk($sformatf("t2[%0d].pc", i), deq_pc_o, vt[i].e_pc);
      chk($sformatf("t2[%0d].instr", i), deq_instr_o, vt[i].e_val ? ~vt[i].e_pc : NOP);
      chk($sformatf("t2[%0d].bp", i), 32'(deq_br_pred_o), 32'(vt[i].e_bp));
      @(posedge clk);
      model_step();
      #1;
    end

    // 3. steady enqueue+dequeue across pointer wrap at count 2
    cyc("t3_pre", 1'b1, 32'h400, 1'b1, 1'b0, 1'b0);
    cyc("t3_pre", 1'b1, 32'h404, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cyc("t3_wrap", 1'b1, 32'h408 + 32'(4 * i), 1'(i), 1'b1, 1'b0);
      chk("t3_count", 32'(count_o), 32'd2);
    end
    cyc("t3_drain", 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    cyc("t3_drain", 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

    // 4. flush with simultaneous enqueue
    for (int i = 0; i < 3; i++) cyc("t4_fill", 1'b1, 32'h500 + 32'(4 * i), 1'b1, 1'b0, 1'b0);
    drive(1'b1, 32'h80, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    chk("t4_preflush_count", 32'(count_o), 32'd3);
    check_model("t4_flushcyc");
    @(posedge clk);
    model_step();
    #1;
    chk("t4_post_count", 32'(count_o), 32'd0);
    chk("t4_post_valid", 32'(deq_valid_o), 32'd0);
    chk("t4_post_ready", 32'(enq_ready_o), 32'd1);
    cyc("t4_enq", 1'b1, 32'h100, 1'b0, 1'b0, 1'b0);
    chk("t4_head_pc", deq_pc_o, 32'h100);
    chk("t4_head_valid", 32'(deq_valid_o), 32'd1);

    // 5. full with simultaneous dequeue: enqueue blocked, then accepted
    for (int i = 0; i < 3; i++) cyc("t5_fill", 1'b1, 32'h600 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
    cyc("t5_full", 1'b1, 32'h300, 1'b1, 1'b1, 1'b0);
    chk("t5_count3", 32'(count_o), 32'd3);
    chk("t5_ready", 32'(enq_ready_o), 32'd1);
    cyc("t5_accept", 1'b1, 32'h304, 1'b1, 1'b0, 1'b0);
    chk("t5_count4", 32'(count_o), 32'd4);
    for (int i = 0; i < 4; i++) cyc("t5_drain", 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

    // 6. reset mid-drain
    cyc("t6_fill", 1'b1, 32'h700, 1'b1, 1'b0, 1'b0);
    cyc("t6_fill", 1'b1, 32'h704, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("t6_valid_drop", 32'(deq_valid_o), 32'd0);
    chk("t6_count", 32'(count_o), 32'd0);
    mq.delete();
    @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    cyc("t6_enq", 1'b1, 32'h200, 1'b1, 1'b0, 1'b0);
    chk("t6_first_pc", deq_pc_o, 32'h200);
    cyc("t6_deq", 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      cyc("rnd", ($urandom % 4) != 0, $urandom, 1'($urandom), ($urandom % 3) != 0,
          ($urandom % 25) == 0);
    end
    cyc("final", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
